// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 24-hour BCD hh:mm:ss keeper with button-driven set mode and blink phase.
// Optional macro CLOCK_CHIME_EN adds a one-cycle hourly chime pulse.
module clock_time_keeper #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk_100MHz,
  input  logic       rst_time_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] L_sec,
  output logic [3:0] H_sec,
  output logic [3:0] L_min,
  output logic [3:0] H_min,
  output logic [3:0] L_hour,
  output logic [3:0] H_hour,
  output logic [1:0] select_time,
  output logic       change_out,
  output logic       chime
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
  // Encoding equals select_time, so mode advance is a decrement modulo 4.
  typedef enum logic [1:0] {RUN = 2'd0, SET_SEC = 2'd1, SET_MIN = 2'd2, SET_HOUR = 2'd3} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic change_q, change_d;
  logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic tick, edit, sec_wrap, min_wrap;
  function automatic logic [7:0] inc2(input logic [7:0] v, input logic [7:0] max);
    return v == max ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  always_comb begin
    tick = state_q == RUN && presc_q == PMAX;
    edit = btn_inc && !btn_mode && state_q != RUN;
    sec_wrap = sec_q == 8'h59;
    min_wrap = min_q == 8'h59;
    state_d = btn_mode ? state_e'(state_q - 2'd1) : state_q;
    presc_d = (state_q != RUN || tick) ? '0 : presc_q + 1'b1;
    blink_d = (state_d == RUN || btn_mode || blink_q == BMAX) ? '0 : blink_q + 1'b1;
    change_d = state_d == RUN ? 1'b0 : btn_mode ? 1'b1 : blink_q == BMAX ? ~change_q : change_q;
    sec_d = (tick || (edit && state_q == SET_SEC)) ? inc2(sec_q, 8'h59) : sec_q;
    min_d = ((tick && sec_wrap) || (edit && state_q == SET_MIN)) ? inc2(min_q, 8'h59) : min_q;
    hour_d = ((tick && sec_wrap && min_wrap) || (edit && state_q == SET_HOUR)) ? inc2(hour_q, 8'h23) : hour_q;
  end
  always_ff @(posedge clk_100MHz or negedge rst_time_n) begin
    if (!rst_time_n) begin
      state_q  <= RUN;
      presc_q  <= '0;
      blink_q  <= '0;
      change_q <= 1'b0;
      sec_q    <= 8'h00;
      min_q    <= 8'h00;
      hour_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      blink_q  <= blink_d;
      change_q <= change_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
    end
  end
`ifdef CLOCK_CHIME_EN
  logic chime_q;
  always_ff @(posedge clk_100MHz or negedge rst_time_n) begin
    if (!rst_time_n) chime_q <= 1'b0;
    else chime_q <= tick && sec_wrap && min_wrap;
  end
  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif
  assign {H_sec, L_sec}   = sec_q;
  assign {H_min, L_min}   = min_q;
  assign {H_hour, L_hour} = hour_q;
  assign select_time = state_q;
  assign change_out  = change_q;
endmodule

// File: tb/tb_clock_time_keeper.sv
// tb_clock_time_keeper: directed self-checking bench for clock_time_keeper with TICK_DIV=10, BLINK_DIV=4.
module tb_clock_time_keeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  logic [3:0] L_sec, H_sec, L_min, H_min, L_hour, H_hour;
  logic [1:0] sel;
  logic chg, chime;
  logic [23:0] tm;
  logic chime_exp;
  int checks = 0;
  int failures = 0;

  clock_time_keeper #(.TICK_DIV(10), .BLINK_DIV(4)) dut (
    .clk_100MHz(clk), .rst_time_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .L_sec(L_sec), .H_sec(H_sec), .L_min(L_min), .H_min(H_min),
    .L_hour(L_hour), .H_hour(H_hour), .select_time(sel), .change_out(chg), .chime(chime)
  );

  always #5 clk = ~clk;
  assign tm = {H_hour, L_hour, H_min, L_min, H_sec, L_sec};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i);
    btn_mode = m;
    btn_inc = i;
    step(1);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
  endtask

  task automatic incs(input int n);
    btn_inc = 1'b1;
    step(n);
    btn_inc = 1'b0;
  endtask

  initial begin
`ifdef CLOCK_CHIME_EN
    chime_exp = 1'b1;
`else
    chime_exp = 1'b0;
`endif
    step(5);
    chk("reset_time", tm, 24'h000000);
    chk("reset_sel", sel, 2'd0);
    chk("reset_chg", chg, 1'b0);
    chk("reset_chime", chime, 1'b0);
    rst_n = 1'b1;
    step(9);
    chk("pre_first_tick", tm, 24'h000000);
    step(1);
    chk("first_tick", tm, 24'h000001);
    chk("first_tick_chime", chime, 1'b0);
    // mode cycling and blink phase
    pulse(1'b1, 1'b0);
    chk("mode1_sel", sel, 2'd3);
    chk("mode1_chg", chg, 1'b1);
    step(3);
    chk("blink_hold", chg, 1'b1);
    step(1);
    chk("blink_toggle0", chg, 1'b0);
    step(4);
    chk("blink_toggle1", chg, 1'b1);
    chk("set_frozen_a", tm, 24'h000001);
    pulse(1'b1, 1'b0);
    chk("mode2_sel", sel, 2'd2);
    chk("mode2_chg", chg, 1'b1);
    pulse(1'b1, 1'b0);
    chk("mode3_sel", sel, 2'd1);
    chk("mode3_chg", chg, 1'b1);
    pulse(1'b1, 1'b0);
    chk("mode4_sel", sel, 2'd0);
    chk("mode4_chg", chg, 1'b0);
    step(9);
    chk("restart_no_tick", tm, 24'h000001);
    step(1);
    chk("restart_tick", tm, 24'h000002);
    // field wrap and time set to 23:59:59
    pulse(1'b1, 1'b0);
    incs(22);
    chk("hour_22", tm, 24'h220002);
    incs(1);
    chk("hour_23", tm, 24'h230002);
    incs(1);
    chk("hour_wrap", tm, 24'h000002);
    incs(23);
    chk("hour_set23", tm, 24'h230002);
    pulse(1'b1, 1'b0);
    incs(59);
    chk("min_59", tm, 24'h235902);
    incs(1);
    chk("min_wrap", tm, 24'h230002);
    incs(59);
    pulse(1'b1, 1'b1);
    chk("simul_sel", sel, 2'd1);
    chk("simul_min", tm, 24'h235902);
    incs(57);
    chk("sec_59", tm, 24'h235959);
    step(30);
    chk("set_frozen_b", tm, 24'h235959);
    chk("set_frozen_sel", sel, 2'd1);
    pulse(1'b1, 1'b0);
    chk("run_sel", sel, 2'd0);
    chk("run_chg", chg, 1'b0);
    chk("edit_no_chime", chime, 1'b0);
    step(9);
    chk("pre_rollover", tm, 24'h235959);
    chk("pre_rollover_chime", chime, 1'b0);
    step(1);
    chk("rollover", tm, 24'h000000);
    chk("rollover_chime", chime, chime_exp);
    step(1);
    chk("chime_one_cycle", chime, 1'b0);
    chk("post_rollover", tm, 24'h000000);
    // async reset mid-edit
    pulse(1'b1, 1'b0);
    incs(12);
    pulse(1'b1, 1'b0);
    incs(34);
    pulse(1'b1, 1'b0);
    incs(56);
    chk("edit_123456", tm, 24'h123456);
    chk("edit_sel", sel, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_time", tm, 24'h000000);
    chk("async_rst_sel", sel, 2'd0);
    chk("async_rst_chg", chg, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("after_rst_time", tm, 24'h000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

- Produces the six BCD time digits, the edit-field select and the blink phase consumed by the seven-segment display driver.
- Runs a 24-hour hh:mm:ss count from the 100 MHz system clock.
- Accepts two debounced single-cycle button pulses to enter set mode, pick a field, and increment it.
- Sits between the button conditioning logic and the display block.

## Interface
- TICK_DIV, 100000000: clock cycles per second tick.
- BLINK_DIV, 50000000: clock cycles per `change_out` half-period in set mode.
- clk_100MHz  input  1  system clock; all state changes on its rising edge.
- rst_time_n  input  1  asynchronous, active-low reset.
- btn_mode  input  1  one-cycle pulse; advances the mode.
- btn_inc  input  1  one-cycle pulse; increments the selected field.
- L_sec, H_sec  output  4 each  seconds units (0-9) and tens (0-5), BCD.
- L_min, H_min  output  4 each  minutes units (0-9) and tens (0-5), BCD.
- L_hour, H_hour  output  4 each  hours units (0-9) and tens (0-2), BCD.
- select_time  output  2  0 = run, 1 = seconds, 2 = minutes, 3 = hours being edited.
- change_out  output  1  blink phase; when 1, the display blanks the selected field.
- chime  output  1  one-cycle hourly pulse (see Configuration).

## Operation
- **FSM states:** RUN (select_time 0), SET_HOUR (3), SET_MIN (2), SET_SEC (1).
- **btn_mode transitions:** RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- **RUN:**
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - When the count equals TICK_DIV-1, seconds increment with full carry: 59 s -> 00 plus one minute; 59 min -> 00 plus one hour; 23 -> 00.
  - btn_inc is ignored.
- **SET states:**
  - Prescaler is held at 0; time does not advance.
  - btn_inc increments only the selected field, with no carry out: sec 59 -> 00, min 59 -> 00, hour 23 -> 00.
  - Hour increments 09 -> 10 and 19 -> 20 through BCD digit carry.
- **change_out:**
  - In SET states, toggles every BLINK_DIV cycles, starting at 1 on the cycle after entering SET_HOUR.
  - In RUN it is forced to 0 and its counter is cleared.
  - Its counter is cleared, and change_out set to 1, on every mode change between SET states.
- **Simultaneous events:**
  - btn_mode and btn_inc in the same cycle: btn_mode is taken, btn_inc is discarded.
  - A tick in the cycle btn_mode is accepted from RUN: the tick is applied, because the state at the edge governs.
- **Leaving SET_SEC to RUN:** prescaler restarts from 0, so the first tick comes TICK_DIV cycles later.
- **Digit range:** every output digit is always a legal BCD value within its range; no illegal time is ever presented.

## Timing
- **Reset** (rst_time_n low, asynchronous):
  - All digits 0 (00:00:00), select_time 0, change_out 0, chime 0.
  - Prescaler and blink counter 0; state RUN.
- **Reset release:** first tick at the TICK_DIV-th rising edge after rst_time_n rises.
- **Reset mid-edit:** returns to RUN at 00:00:00 immediately; the interrupted edit is lost.
- **Registered outputs:** all outputs are registered.
- **Latencies:**
  - Tick to updated digits: 1 cycle.
  - btn_mode to select_time change: 1 cycle.
  - btn_inc to field change: 1 cycle.
- **Carry:** a full carry (23:59:59 -> 00:00:00) completes in a single edge; no intermediate values are visible.
- **Button spacing:** back-to-back button pulses on consecutive cycles are each honoured.

## Configuration
- Macro: CLOCK_CHIME_EN.
- **Defined:** chime pulses high for exactly one cycle on the same edge that a RUN-mode tick makes min:sec 00:00, including the 23:59:59 rollover. Edits in SET states never chime.
- **Undefined:** chime is tied to 0 and the chime logic is absent.

## Test plan
- All scenarios run with TICK_DIV=10, BLINK_DIV=4.
- **Reset and first tick:** hold rst_time_n low 5 cycles, release -> outputs 00:00:00, select_time 0, change_out 0; 00:00:01 appears after 10 edges.
- **Full rollover:** drive time to 23:59:59 via SET mode, return to RUN, wait 10 cycles -> 00:00:00 in one step; chime is one 1-cycle pulse with CLOCK_CHIME_EN, 0 without.
- **Mode cycling:** pulse btn_mode 4 times -> select_time 3, 2, 1, 0; change_out is 1 right after the first pulse, toggles every 4 cycles in SET, and is 0 in RUN.
- **Field wrap:** in SET_HOUR from 22, 2 btn_inc -> 23 then 00 with minutes unchanged; in SET_MIN from 59, 1 btn_inc -> 00 with hours unchanged.
- **Simultaneous buttons and frozen time:** in SET_MIN, btn_mode and btn_inc together -> select_time 1, minutes unchanged; 30 idle cycles in SET -> seconds unchanged.
- **Async reset mid-edit:** in SET_SEC at 12:34:56, assert rst_time_n low between clock edges -> outputs go to 00:00:00, select_time 0 without waiting for a clock edge.
